// File: rtl/hdmi_period_scheduler.sv
// Delays the timing-generator pixel stream by 12 cycles and inserts the HDMI video preamble and
// leading guard band ahead of each active-video run. Fixed latency, no backpressure.
module hdmi_period_scheduler #(
  parameter bit HDMI_MODE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [23:0] rgb_in,
  output logic        video_active,
  output logic [7:0]  data_ch0,
  output logic [7:0]  data_ch1,
  output logic [7:0]  data_ch2,
  output logic        c0_ch0,
  output logic        c1_ch0,
  output logic        c0_ch1,
  output logic        c1_ch1,
  output logic        c0_ch2,
  output logic        c1_ch2,
  output logic        guard_en,
  output logic [9:0]  guard_ch0,
  output logic [9:0]  guard_ch1,
  output logic [9:0]  guard_ch2,
  output logic        short_blank
);

  localparam int LATENCY      = 12;
  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int MIN_BLANK    = 12;
  // The output registers form the last delay stage.
  localparam int STAGES       = LATENCY - 1;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } pix_t;

  typedef enum logic [2:0] {
    S_CONTROL,
    S_ARM,
    S_PREAMBLE,
    S_GUARD,
    S_VIDEO
  } state_t;

  pix_t       pipe [STAGES];
  pix_t       tail;
  logic [3:0] gap_cnt;
  logic       de_prev;
  logic       rise;
  logic       long_gap;
  logic       qualified;
  logic       unqualified;
  state_t     state;
  logic [2:0] cnt;

  assign tail        = pipe[STAGES-1];
  assign rise        = de_in && !de_prev;
  assign long_gap    = (gap_cnt >= 4'(MIN_BLANK));
  assign qualified   = HDMI_MODE && rise && long_gap;
  assign unqualified = HDMI_MODE && rise && !long_gap;

  assign c1_ch1    = 1'b0;
  assign c0_ch2    = 1'b0;
  assign c1_ch2    = 1'b0;
  assign guard_ch0 = 10'b1011001100;
  assign guard_ch1 = 10'b0100110011;
  assign guard_ch2 = 10'b1011001100;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
      video_active <= 1'b0;
      data_ch0     <= '0;
      data_ch1     <= '0;
      data_ch2     <= '0;
      c0_ch0       <= 1'b0;
      c1_ch0       <= 1'b0;
    end else begin
      pipe[0] <= '{de: de_in, hs: hsync_in, vs: vsync_in, rgb: rgb_in};
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
      video_active <= tail.de;
      data_ch0     <= tail.de ? tail.rgb[7:0]   : 8'h00;
      data_ch1     <= tail.de ? tail.rgb[15:8]  : 8'h00;
      data_ch2     <= tail.de ? tail.rgb[23:16] : 8'h00;
      c0_ch0       <= tail.hs;
      c1_ch0       <= tail.vs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt     <= '0;
      de_prev     <= 1'b0;
      short_blank <= 1'b0;
    end else begin
      de_prev <= de_in;
      if (de_in)
        gap_cnt <= '0;
      else if (gap_cnt != 4'hF)
        gap_cnt <= gap_cnt + 4'd1;
      if (unqualified)
        short_blank <= 1'b1;
    end
  end

  // S_ARM spends the one cycle between the detected edge and the first preamble cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CONTROL;
      cnt      <= '0;
      c0_ch1   <= 1'b0;
      guard_en <= 1'b0;
    end else begin
      guard_en <= (state == S_GUARD);
      case (state)
        S_CONTROL: begin
          if (qualified)
            state <= S_ARM;
        end
        S_ARM: begin
          state  <= S_PREAMBLE;
          c0_ch1 <= 1'b1;
          cnt    <= '0;
        end
        S_PREAMBLE: begin
          if (cnt == 3'(PREAMBLE_LEN - 1)) begin
            state  <= S_GUARD;
            c0_ch1 <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        S_GUARD: begin
          if (cnt == 3'(GUARD_LEN - 1))
            state <= S_VIDEO;
          else
            cnt <= cnt + 3'd1;
        end
        S_VIDEO: begin
          // tail.de is what video_active shows next cycle.
          if (!tail.de)
            state <= S_CONTROL;
        end
        default: state <= S_CONTROL;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench: HDMI and DVI instances share one stimulus stream; outputs are checked every cycle
// against the input history delayed 12 cycles and against hand-placed preamble/guard/short_blank windows.
module tb_hdmi_period_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        de_in, hsync_in, vsync_in;
  logic [23:0] rgb_in;

  logic       va, c0_0, c1_0, c0_1, c1_1, c0_2, c1_2, grd, sb;
  logic [7:0] d0, d1, d2;
  logic [9:0] g0, g1, g2;

  logic       va_v, c0_0v, c1_0v, c0_1v, c1_1v, c0_2v, c1_2v, grd_v, sb_v;
  logic [7:0] d0_v, d1_v, d2_v;
  logic [9:0] g0_v, g1_v, g2_v;

  always #5 clk = ~clk;

  hdmi_period_scheduler #(.HDMI_MODE(1'b1)) dut (
    .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
    .video_active(va), .data_ch0(d0), .data_ch1(d1), .data_ch2(d2),
    .c0_ch0(c0_0), .c1_ch0(c1_0), .c0_ch1(c0_1), .c1_ch1(c1_1), .c0_ch2(c0_2), .c1_ch2(c1_2),
    .guard_en(grd), .guard_ch0(g0), .guard_ch1(g1), .guard_ch2(g2), .short_blank(sb)
  );

  hdmi_period_scheduler #(.HDMI_MODE(1'b0)) dut_dvi (
    .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
    .video_active(va_v), .data_ch0(d0_v), .data_ch1(d1_v), .data_ch2(d2_v),
    .c0_ch0(c0_0v), .c1_ch0(c1_0v), .c0_ch1(c0_1v), .c1_ch1(c1_1v), .c0_ch2(c0_2v), .c1_ch2(c1_2v),
    .guard_en(grd_v), .guard_ch0(g0_v), .guard_ch1(g1_v), .guard_ch2(g2_v), .short_blank(sb_v)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rst = -1;
  int qt = -1000;
  int sb_at = 1 << 30;
  int cnt_va, cnt_ctl0, cnt_grd;
  logic        de_h  [0:2047];
  logic        hs_h  [0:2047];
  logic        vs_h  [0:2047];
  logic [23:0] rgb_h [0:2047];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    int k;
    logic ed, eh, ev, ectl, egrd, esb;
    logic [23:0] ep;
    k = cyc - 12;
    ed = 1'b0; eh = 1'b0; ev = 1'b0; ep = '0;
    if (k > last_rst) begin
      ed = de_h[k]; eh = hs_h[k]; ev = vs_h[k]; ep = de_h[k] ? rgb_h[k] : 24'h0;
    end
    ectl = (qt >= 0) && (cyc >= qt + 2) && (cyc <= qt + 9);
    egrd = (qt >= 0) && (cyc >= qt + 11) && (cyc <= qt + 12);
    esb  = (cyc >= sb_at);
    check_val("video_active", 32'(va), 32'(ed));
    check_val("data_ch0", 32'(d0), 32'(ep[7:0]));
    check_val("data_ch1", 32'(d1), 32'(ep[15:8]));
    check_val("data_ch2", 32'(d2), 32'(ep[23:16]));
    check_val("c0_ch0_hsync", 32'(c0_0), 32'(eh));
    check_val("c1_ch0_vsync", 32'(c1_0), 32'(ev));
    check_val("ctl0", 32'(c0_1), 32'(ectl));
    check_val("ctl1_3", 32'({c1_1, c0_2, c1_2}), 32'd0);
    check_val("guard_en", 32'(grd), 32'(egrd));
    check_val("short_blank", 32'(sb), 32'(esb));
    check_val("dvi_video_active", 32'(va_v), 32'(ed));
    check_val("dvi_data", 32'({d2_v, d1_v, d0_v}), 32'(ep));
    check_val("dvi_syncs", 32'({c1_0v, c0_0v}), 32'({ev, eh}));
    check_val("dvi_ctl", 32'({c0_1v, c1_1v, c0_2v, c1_2v, grd_v, sb_v}), 32'd0);
    cnt_va   += int'(va);
    cnt_ctl0 += int'(c0_1);
    cnt_grd  += int'(grd);
  endtask

  // One input cycle; syncs follow a fixed pattern so they toggle through every phase.
  task automatic drive(input logic r, input logic d, input logic [23:0] p);
    rst = r; de_in = d; rgb_in = p;
    hsync_in = ((cyc % 3) == 0);
    vsync_in = ((cyc % 7) < 3);
    de_h[cyc] = d; hs_h[cyc] = hsync_in; vs_h[cyc] = vsync_in; rgb_h[cyc] = p;
    if (r) last_rst = cyc;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      qt = -1000;
      sb_at = 1 << 30;
    end
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 24'h0);
  endtask

  task automatic line(input int n, input logic [23:0] p);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, p);
  endtask

  task automatic zero_counts();
    cnt_va = 0; cnt_ctl0 = 0; cnt_grd = 0;
  endtask

  initial begin
    int t;
    rst = 1'b1; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; rgb_in = '0;
    zero_counts();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 24'h0);

    check_val("guard_ch0", 32'(g0), 32'(10'b1011001100));
    check_val("guard_ch1", 32'(g1), 32'(10'b0100110011));
    check_val("guard_ch2", 32'(g2), 32'(10'b1011001100));

    // Qualified 4-cycle line after 20 idle cycles.
    idle(20);
    zero_counts();
    qt = cyc;
    line(4, 24'h112233);
    idle(24);
    check_val("t1_va_cycles", 32'(cnt_va), 32'd4);
    check_val("t1_ctl0_cycles", 32'(cnt_ctl0), 32'd8);
    check_val("t1_guard_cycles", 32'(cnt_grd), 32'd2);

    // Second line after an 11-cycle gap is unqualified.
    zero_counts();
    qt = cyc;
    line(4, 24'hA5C3F0);
    idle(11);
    sb_at = cyc + 1;
    line(4, 24'h0F1E2D);
    idle(100);
    check_val("t3_va_cycles", 32'(cnt_va), 32'd8);
    check_val("t3_ctl0_cycles", 32'(cnt_ctl0), 32'd8);
    check_val("t3_guard_cycles", 32'(cnt_grd), 32'd2);
    check_val("t3_short_blank_held", 32'(sb), 32'd1);

    // Reset at t+5 of a preamble, then a rise 5 cycles after release.
    zero_counts();
    t = cyc;
    qt = t;
    line(4, 24'h445566);
    idle(1);
    drive(1'b1, 1'b0, 24'h0);
    check_val("rst_va", 32'(va), 32'd0);
    check_val("rst_ctl0", 32'(c0_1), 32'd0);
    check_val("rst_short_blank", 32'(sb), 32'd0);
    idle(5);
    sb_at = cyc + 1;
    line(4, 24'h778899);
    idle(15);
    check_val("rst_va_cycles", 32'(cnt_va), 32'd4);
    check_val("rst_ctl0_cycles", 32'(cnt_ctl0), 32'd4);
    check_val("rst_guard_cycles", 32'(cnt_grd), 32'd0);
    check_val("rst_short_blank_set", 32'(sb), 32'd1);

    // 1-cycle pulse after a 15-cycle gap.
    zero_counts();
    qt = cyc;
    line(1, 24'hDEADBE);
    idle(25);
    check_val("pulse_va_cycles", 32'(cnt_va), 32'd1);
    check_val("pulse_ctl0_cycles", 32'(cnt_ctl0), 32'd8);
    check_val("pulse_guard_cycles", 32'(cnt_grd), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hdmi_period_scheduler.md
# hdmi_period_scheduler

Sequences the per-channel TMDS encoders for DVI/HDMI video output. It takes the raw pixel stream from the video timing generator (DE, HSYNC, VSYNC, RGB) and delays it by a fixed pipeline. It uses the lookahead to insert the HDMI video preamble and the video leading guard band ahead of every active-video run. Its outputs drive the three encoder instances directly (video_active, data, c0/c1), plus a guard-band override that the serializer-side mux applies in the cycle the encoders' outputs appear.

## Interface
- HDMI_MODE, 1: 1 = insert preamble and guard band; 0 = plain DVI, with control codes only and no guard band (latency unchanged).
- Fixed constants: LATENCY = 12, PREAMBLE_LEN = 8, GUARD_LEN = 2, MIN_BLANK = 12.
- clk  in  1  pixel clock, the only clock.
- rst  in  1  reset, synchronous, active-high.
- de_in  in  1  data enable from the timing generator.
- hsync_in  in  1  horizontal sync, passed through at its native polarity.
- vsync_in  in  1  vertical sync, passed through at its native polarity.
- rgb_in  in  24  pixel: R[23:16], G[15:8], B[7:0].
- video_active  out  1  to all three encoders.
- data_ch0 / data_ch1 / data_ch2  out  8 each  B / G / R to encoders 0 / 1 / 2.
- c0_ch0, c1_ch0  out  1 each  delayed hsync and vsync.
- c0_ch1, c1_ch1, c0_ch2, c1_ch2  out  1 each  CTL0, CTL1, CTL2, CTL3.
- guard_en  out  1  replace the encoder outputs with the guard codes; aligned to encoder output (one cycle after encoder input).
- guard_ch0 / guard_ch1 / guard_ch2  out  10 each  1011001100 / 0100110011 / 1011001100; constant values.
- short_blank  out  1  sticky: a blanking gap shorter than MIN_BLANK was detected.

## Operation
- Delay line: de, hsync, vsync and rgb are delayed LATENCY cycles. The delayed values drive video_active, data_chN, c0_ch0 and c1_ch0.
  - data_chN is forced to 0 whenever the delayed de is 0.
- gap_cnt: 4 bits. Increments each cycle that de_in = 0 and saturates at 15. Clears to 0 on the cycle de_in = 1.
- A de_in rising edge (de_in = 1 while the previous de_in = 0) is a "qualified start" when gap_cnt ≥ MIN_BLANK and HDMI_MODE = 1.
- State machine, indexed on encoder-input cycles, with the rising edge at input cycle t:
  - CONTROL: CTL0–3 = 0, guard off.
    - Qualified start at t → PREAMBLE at t+2.
  - PREAMBLE: 8 cycles, t+2..t+9. CTL0 = 1, CTL1 = CTL2 = CTL3 = 0. Then GUARD.
  - GUARD: 2 cycles, t+10..t+11. Encoder inputs are as in CONTROL. Then VIDEO.
  - VIDEO: from t+12. Stays while the delayed de = 1. Returns to CONTROL on the first cycle the delayed de = 0.
- Unqualified start:
  - gap_cnt < MIN_BLANK with HDMI_MODE = 1: no preamble or guard. Video is still emitted at t+12, and short_blank is set to 1 on cycle t+1.
  - HDMI_MODE = 0: no preamble, no guard, and short_blank is never set.
- A 1-cycle de pulse gets the full preamble, the guard band, and 1 video cycle.
- The next rising edge cannot occur before VIDEO ends, because a qualified start requires ≥ 12 idle cycles.
- c0_ch0 and c1_ch0 carry the delayed syncs in every state, including PREAMBLE and GUARD.

## Timing
- Reset values: all pipeline stages 0, so the delayed de, hsync, vsync and rgb are all 0.
  - video_active = 0, all data = 0, all c0/c1 = 0, guard_en = 0, short_blank = 0.
  - gap_cnt = 0; state CONTROL.
- Reset applied mid-line aborts any preamble, guard or video immediately on the next edge. Because gap_cnt = 0 after reset, a de_in rise within 12 cycles of reset release is unqualified.
- Latency: de_in/rgb_in at cycle t → video_active/data at cycle t+12. All outputs are registered.
- guard_en is high in cycles t+11 and t+12, i.e. the GUARD input cycles +1, matching the encoder's 1-cycle register.
- short_blank clears only on rst.

## Test plan
- Reset, then de_in low for 20 cycles, then de_in high for 4 cycles with rgb_in = 0x112233 → video_active high in the 4 cycles t+12..t+15; data_ch2/1/0 = 0x11/0x22/0x33; CTL0 = 1 exactly in t+2..t+9; guard_en high exactly in t+11..t+12; short_blank = 0.
- Toggle hsync_in and vsync_in across blanking and the preamble → c0_ch0/c1_ch0 equal the inputs delayed 12 cycles in every cycle; CTL1–3 always 0.
- Two lines with an 11-cycle de_in gap → second line has no CTL0 pulse and no guard_en; video still at +12; short_blank rises at t+1 and stays high through 100 further cycles.
- HDMI_MODE = 0, same stimulus as the first test → identical video_active/data timing; CTL0–3 and guard_en never asserted.
- Assert rst during cycle t+5 of a preamble → next cycle all outputs are at their reset values; a de_in rise 5 cycles after release produces no preamble and sets short_blank.
- 1-cycle de_in pulse after a 15-cycle gap → 8 preamble cycles, 2 guard_en cycles, exactly 1 video_active cycle at t+12.
